// File: rtl/fpga_status_led_ctrl.sv
// Board status LED controller: per-channel off/on/heartbeat/activity modes,
// with a sticky exit-status latch that overrides all LEDs with pass/fail.
module fpga_status_led_ctrl #(
    parameter int unsigned NUM_LEDS       = 4,
    parameter int unsigned PRESCALE_W     = 27,
    parameter int unsigned FAST_SHIFT     = 3,
    parameter int unsigned STRETCH_CYCLES = 1000000,
    parameter int unsigned EXIT_W         = 32
) (
    input  logic                    clk_gen,
    input  logic                    rst_n,
    input  logic [2*NUM_LEDS-1:0]   mode_i,
    input  logic [NUM_LEDS-1:0]     activity_i,
    input  logic                    exit_valid_i,
    input  logic [EXIT_W-1:0]       exit_value_i,
    output logic [NUM_LEDS-1:0]     led_o,
    output logic                    heartbeat_o,
    output logic                    exit_latched_o,
    output logic                    exit_pass_o,
    output logic [EXIT_W-1:0]       exit_code_o
);

    localparam int unsigned ST_W     = $clog2(STRETCH_CYCLES + 1);
    localparam int unsigned HB_BIT   = PRESCALE_W - 1;
    localparam int unsigned FAST_BIT = PRESCALE_W - 1 - FAST_SHIFT;
    localparam logic [ST_W-1:0] ST_RELOAD = ST_W'(STRETCH_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_HEART = 2'b10,
        MODE_ACT   = 2'b11
    } led_mode_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_EXIT = 1'b1
    } state_e;

    state_e                         state_q;
    state_e                         state_d;
    logic [PRESCALE_W-1:0]          cnt_q;
    logic [NUM_LEDS-1:0][ST_W-1:0]  st_q;
    logic [NUM_LEDS-1:0][ST_W-1:0]  st_d;
    logic [NUM_LEDS-1:0]            act_c;
    logic [NUM_LEDS-1:0]            led_d;
    logic                           exit_valid_q;
    logic                           exit_edge_c;
    logic                           capture_c;
    logic                           fast_c;

    assign heartbeat_o    = cnt_q[HB_BIT];
    assign fast_c         = cnt_q[FAST_BIT];
    assign exit_latched_o = (state_q == ST_EXIT);
    assign exit_edge_c    = exit_valid_i & ~exit_valid_q;
    assign capture_c      = exit_edge_c & (state_q == ST_RUN);

    // Free-running blink prescaler
    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + PRESCALE_W'(1);
        end
    end

    // Retriggerable activity stretchers, independent of mode
    always_comb begin
        st_d  = st_q;
        act_c = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            act_c[i] = activity_i[i] | (st_q[i] != '0);
            if (activity_i[i]) begin
                st_d[i] = ST_RELOAD;
            end else if (st_q[i] != '0) begin
                st_d[i] = st_q[i] - ST_W'(1);
            end else begin
                st_d[i] = '0;
            end
        end
    end

    // Stretch counter registers
    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            st_q <= '0;
        end else begin
            st_q <= st_d;
        end
    end

    // Exit latch state register
    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Exit latch next state: first rising edge of exit_valid locks it
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (exit_edge_c) state_d = ST_EXIT;
            ST_EXIT: state_d = ST_EXIT;
            default: state_d = ST_RUN;
        endcase
    end

    // Edge detector and captured exit value
    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            exit_valid_q <= 1'b0;
            exit_code_o  <= '0;
            exit_pass_o  <= 1'b0;
        end else begin
            exit_valid_q <= exit_valid_i;
            if (capture_c) begin
                exit_code_o <= exit_value_i;
                exit_pass_o <= (exit_value_i == '0);
            end
        end
    end

    // LED selection: per-channel mode, or global pass/fail override
    always_comb begin
        led_d = '0;
        if (state_q == ST_EXIT) begin
            led_d = exit_pass_o ? {NUM_LEDS{1'b1}} : {NUM_LEDS{fast_c}};
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                case (led_mode_e'(mode_i[2*i +: 2]))
                    MODE_OFF:   led_d[i] = 1'b0;
                    MODE_ON:    led_d[i] = 1'b1;
                    MODE_HEART: led_d[i] = cnt_q[HB_BIT];
                    MODE_ACT:   led_d[i] = act_c[i];
                    default:    led_d[i] = 1'b0;
                endcase
            end
        end
    end

    // Registered LED drive
    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            led_o <= '0;
        end else begin
            led_o <= led_d;
        end
    end

endmodule
